// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the 32-point radix-2 SDF FFT datapath.
//   N_FFT        transform length
//   DATA_W       signed width of each internal real/imag component
//   OUT_W        signed width of each output component
//   STAGE_DEPTH  feedback delay depth of each SDF stage, stage 1 first
//   cplx_t       packed complex sample at internal width
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int N_FFT  = 32;
    localparam int DATA_W = 22;
    localparam int OUT_W  = 16;

    localparam int STAGE_DEPTH [0:4] = '{16, 8, 4, 2, 1};

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_delay_bank.sv
// -----------------------------------------------------------------------------
// sdf_delay_bank
// DEPTH-entry circular storage of {real, imag, vld}. One enabled write port and
// one combinational read port share the same slot pointer, so the read returns
// the slot's old contents in the cycle it is overwritten.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (clears valid bits only)
//   i_we       write i_wr_* into slot i_ptr at the next edge
//   i_clr      synchronous clear of every valid bit (wins over i_we)
//   i_ptr      slot addressed by both ports
//   i_wr_real  sample to store, real
//   i_wr_imag  sample to store, imag
//   o_rd_real  slot i_ptr contents, real; 0 when slot not valid
//   o_rd_imag  slot i_ptr contents, imag; 0 when slot not valid
// -----------------------------------------------------------------------------
module sdf_delay_bank #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 22,
    parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic                     i_clr,
    input  logic [PTR_W-1:0]         i_ptr,
    input  logic signed [DATA_W-1:0] i_wr_real,
    input  logic signed [DATA_W-1:0] i_wr_imag,
    output logic signed [DATA_W-1:0] o_rd_real,
    output logic signed [DATA_W-1:0] o_rd_imag
);

    logic signed [DATA_W-1:0] r_real [DEPTH];
    logic signed [DATA_W-1:0] r_imag [DEPTH];
    logic [DEPTH-1:0]         r_vld;

    // Data flops carry no reset; emptiness is tracked solely by r_vld.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_we && !i_clr && (i_ptr == PTR_W'(i))) begin
                r_real[i] <= i_wr_real;
                r_imag[i] <= i_wr_imag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (i_clr) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_we && (i_ptr == PTR_W'(i))) begin
                    r_vld[i] <= 1'b1;
                end
            end
        end
    end

    // Read mux built from slot compares so the pointer never indexes past DEPTH-1
    // for non-power-of-two depths.
    always_comb begin
        o_rd_real = '0;
        o_rd_imag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i_ptr == PTR_W'(i)) && r_vld[i]) begin
                o_rd_real = r_real[i];
                o_rd_imag = r_imag[i];
            end
        end
    end

endmodule

// File: rtl/sdf_feedback_delay.sv
// -----------------------------------------------------------------------------
// sdf_feedback_delay
// Feedback delay line closing the loop of one radix-2 SDF FFT stage. A sample
// written on shift k is returned on rd_* during shift k+DEPTH; cycles without
// shift_en freeze the line. rd_* comes only from flops, which breaks the
// combinational rd->butterfly->wr loop.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   shift_en   advance the line one slot this cycle
//   flush      synchronous clear of contents, pointer and occupancy (wins over shift_en)
//   wr_real    sample entering the line, real
//   wr_imag    sample entering the line, imag
//   rd_real    sample written DEPTH shifts ago, real; 0 when slot empty
//   rd_imag    same, imag
//   primed     line holds DEPTH samples since reset/flush
//   occupancy  samples held, saturating at DEPTH
//   wrap       pointer at DEPTH-1 while a shift is taken
// -----------------------------------------------------------------------------
module sdf_feedback_delay
    import fft_pkg::STAGE_DEPTH;
#(
    parameter int DEPTH  = STAGE_DEPTH[0],
    parameter int DATA_W = 22,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] wr_real,
    input  logic signed [DATA_W-1:0] wr_imag,
    output logic signed [DATA_W-1:0] rd_real,
    output logic signed [DATA_W-1:0] rd_imag,
    output logic                     primed,
    output logic [CNT_W-1:0]         occupancy,
    output logic                     wrap
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_occ;
    logic             w_we;
    logic             w_ptr_last;

    assign w_we       = shift_en & ~flush;
    assign w_ptr_last = (r_ptr == PTR_W'(DEPTH - 1));

    // For DEPTH=1 w_ptr_last is always true, so r_ptr stays at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_ptr <= '0;
            r_occ <= '0;
        end else if (shift_en) begin
            r_ptr <= w_ptr_last ? '0 : r_ptr + PTR_W'(1);
            if (r_occ != CNT_W'(DEPTH)) begin
                r_occ <= r_occ + CNT_W'(1);
            end
        end
    end

    sdf_delay_bank #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_we),
        .i_clr     (flush),
        .i_ptr     (r_ptr),
        .i_wr_real (wr_real),
        .i_wr_imag (wr_imag),
        .o_rd_real (rd_real),
        .o_rd_imag (rd_imag)
    );

    assign occupancy = r_occ;
    assign primed    = (r_occ == CNT_W'(DEPTH));
    assign wrap      = w_we & w_ptr_last;

endmodule
